// File: rtl/enc8b10b_tx.sv
// Serial 8b/10b transmitter: encodes 9-bit symbols with running disparity and shifts them out a-first.
// Optional build macro TX_IDLE_COMMA_EN fills idle time with K28.5 commas instead of a quiet line.
module enc8b10b_tx (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [8:0] inputdata_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       outputdata_o,
    output logic       sob_o,
    output logic       code_err_o,
    output logic       rd_o
);
    localparam logic [8:0] K28_5 = 9'h1BC;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t     state_q, state_d;
    logic [9:0] shiftReg_q, shiftReg_d;
    logic [3:0] bitCnt_q, bitCnt_d;
    logic       rd_q, rd_d;
    logic       sob_q, sob_d;
    logic       codeErr_q, codeErr_d;

    logic       loadEn, badK;
    logic [8:0] sym;
    logic [4:0] symX;
    logic [2:0] symY;
    logic       symK;
    logic [5:0] base6, code6;
    logic [3:0] base4, code4;
    logic       bal6, bal4, rd6, useA7, flip4, rdAfter;
    logic [9:0] codeWord;

    // RD- column of the 5b/6b table, bits abcdei
    function automatic logic [5:0] enc6Base(input logic [4:0] x);
        case (x)
            5'd0:    enc6Base = 6'b100111;
            5'd1:    enc6Base = 6'b011101;
            5'd2:    enc6Base = 6'b101101;
            5'd3:    enc6Base = 6'b110001;
            5'd4:    enc6Base = 6'b110101;
            5'd5:    enc6Base = 6'b101001;
            5'd6:    enc6Base = 6'b011001;
            5'd7:    enc6Base = 6'b111000;
            5'd8:    enc6Base = 6'b111001;
            5'd9:    enc6Base = 6'b100101;
            5'd10:   enc6Base = 6'b010101;
            5'd11:   enc6Base = 6'b110100;
            5'd12:   enc6Base = 6'b001101;
            5'd13:   enc6Base = 6'b101100;
            5'd14:   enc6Base = 6'b011100;
            5'd15:   enc6Base = 6'b010111;
            5'd16:   enc6Base = 6'b011011;
            5'd17:   enc6Base = 6'b100011;
            5'd18:   enc6Base = 6'b010011;
            5'd19:   enc6Base = 6'b110010;
            5'd20:   enc6Base = 6'b001011;
            5'd21:   enc6Base = 6'b101010;
            5'd22:   enc6Base = 6'b011010;
            5'd23:   enc6Base = 6'b111010;
            5'd24:   enc6Base = 6'b110011;
            5'd25:   enc6Base = 6'b100110;
            5'd26:   enc6Base = 6'b010110;
            5'd27:   enc6Base = 6'b110110;
            5'd28:   enc6Base = 6'b001110;
            5'd29:   enc6Base = 6'b101110;
            5'd30:   enc6Base = 6'b011110;
            default: enc6Base = 6'b101011;
        endcase
    endfunction

    // RD- column of the 3b/4b table (P7 for y=7), bits fghj
    function automatic logic [3:0] enc4Base(input logic [2:0] y);
        case (y)
            3'd0:    enc4Base = 4'b1011;
            3'd1:    enc4Base = 4'b1001;
            3'd2:    enc4Base = 4'b0101;
            3'd3:    enc4Base = 4'b1100;
            3'd4:    enc4Base = 4'b1101;
            3'd5:    enc4Base = 4'b1010;
            3'd6:    enc4Base = 4'b0110;
            default: enc4Base = 4'b1110;
        endcase
    endfunction

    assign badK = inputdata_i[8] &&
                  !((inputdata_i[4:0] == 5'd28) ||
                    ((inputdata_i[7:5] == 3'd7) &&
                     ((inputdata_i[4:0] == 5'd23) || (inputdata_i[4:0] == 5'd27) ||
                      (inputdata_i[4:0] == 5'd29) || (inputdata_i[4:0] == 5'd30))));

    assign ready_o = (state_q == IDLE) || ((state_q == SHIFT) && (bitCnt_q == 4'd9));

`ifdef TX_IDLE_COMMA_EN
    assign loadEn = ready_o;
`else
    assign loadEn = ready_o && valid_i;
`endif

    assign sym = (valid_i && !badK) ? inputdata_i : K28_5;

    // Unbalanced sub-blocks flip RD; K neutral 3b/4b codes are the complement of the D form at RD-
    always_comb begin
        symX  = sym[4:0];
        symY  = sym[7:5];
        symK  = sym[8];
        base6 = (symK && (symX == 5'd28)) ? 6'b001111 : enc6Base(symX);
        bal6  = ($countones(base6) == 3);
        code6 = (rd_q && (!bal6 || (symX == 5'd7))) ? ~base6 : base6;
        rd6   = rd_q ^ !bal6;
        if (symK) begin
            useA7 = (symY == 3'd7);
        end else begin
            useA7 = (symY == 3'd7) &&
                    ((!rd6 && ((symX == 5'd17) || (symX == 5'd18) || (symX == 5'd20))) ||
                     ( rd6 && ((symX == 5'd11) || (symX == 5'd13) || (symX == 5'd14))));
        end
        base4 = useA7 ? 4'b0111 : enc4Base(symY);
        bal4  = ($countones(base4) == 2);
        if (!bal4 || (symY == 3'd3)) begin
            flip4 = rd6;
        end else begin
            flip4 = symK && !rd6;
        end
        code4    = flip4 ? ~base4 : base4;
        codeWord = {code6, code4};
        rdAfter  = rd6 ^ !bal4;
    end

    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        bitCnt_d   = bitCnt_q;
        rd_d       = rd_q;
        sob_d      = 1'b0;
        codeErr_d  = 1'b0;
        if (loadEn) begin
            state_d    = SHIFT;
            shiftReg_d = codeWord;
            bitCnt_d   = 4'd0;
            rd_d       = rdAfter;
            sob_d      = 1'b1;
            codeErr_d  = valid_i && badK;
        end else begin
            case (state_q)
                IDLE: shiftReg_d = '0;
                SHIFT: begin
                    if (bitCnt_q == 4'd9) begin
                        state_d    = IDLE;
                        shiftReg_d = '0;
                    end else begin
                        shiftReg_d = {shiftReg_q[8:0], 1'b0};
                        bitCnt_d   = bitCnt_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
`ifdef TX_IDLE_COMMA_EN
            state_q    <= SHIFT;
`else
            state_q    <= IDLE;
`endif
            shiftReg_q <= '0;
            bitCnt_q   <= 4'd9;
            rd_q       <= 1'b0;
            sob_q      <= 1'b0;
            codeErr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            bitCnt_q   <= bitCnt_d;
            rd_q       <= rd_d;
            sob_q      <= sob_d;
            codeErr_q  <= codeErr_d;
        end
    end

    assign outputdata_o = shiftReg_q[9];
    assign sob_o        = sob_q;
    assign code_err_o   = codeErr_q;
    assign rd_o         = rd_q;

endmodule

// File: tb/tb_enc8b10b_tx.sv
// Self-checking bench for enc8b10b_tx: vector table plus scoreboard of expected code groups.
// Build with TX_IDLE_COMMA_EN defined to exercise the comma-fill variant instead.
module tb_enc8b10b_tx;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [8:0] inputdata_i;
    logic       valid_i;
    logic       ready_o;
    logic       outputdata_o;
    logic       sob_o;
    logic       code_err_o;
    logic       rd_o;

    typedef struct {
        logic [8:0] data;
        logic [9:0] code;
        logic       rd;
        logic       err;
    } vec_t;

    localparam int NVEC = 15;

    vec_t vecs[NVEC];
    vec_t sbQ[$];
    vec_t cur;
    logic [9:0] got;
    int   bitIdx;
    bit   collecting;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lastReadyCyc = 0;
    bit   firstReady;
`ifdef TX_IDLE_COMMA_EN
    logic lastRd;
`endif

    enc8b10b_tx dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .inputdata_i  (inputdata_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .outputdata_o (outputdata_o),
        .sob_o        (sob_o),
        .code_err_o   (code_err_o),
        .rd_o         (rd_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one symbol, hold it until the DUT is ready, and record the expected code group
    task automatic applyStimulus(input vec_t v);
        int waitCnt = 0;
        inputdata_i = v.data;
        valid_i     = 1'b1;
        while (!ready_o && waitCnt < 40) begin
            @(negedge clk_i);
            waitCnt++;
        end
        if (!ready_o) begin
            checkOutput("readyTimeout", 0, 1);
        end else begin
            if (!firstReady) checkOutput("readyGap", cyc - lastReadyCyc, 10);
            firstReady   = 1'b0;
            lastReadyCyc = cyc;
            sbQ.push_back(v);
        end
        @(negedge clk_i);
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sbQ.size() > 0 || collecting) && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        if (sbQ.size() > 0 || collecting) checkOutput("drainTimeout", 1, 0);
    endtask

    // Scoreboard side: collect ten line bits starting at each sob_o and compare
    always @(negedge clk_i) begin
        if (!rst_i) begin
            collecting = 1'b0;
            bitIdx     = 0;
`ifdef TX_IDLE_COMMA_EN
            lastRd     = 1'b0;
`endif
        end else if (sob_o) begin
            if (collecting) checkOutput("sobBeforeBitJ", bitIdx, 10);
            if (sbQ.size() > 0) begin
                cur = sbQ.pop_front();
            end else begin
`ifdef TX_IDLE_COMMA_EN
                cur.data = 9'h1BC;
                cur.code = lastRd ? 10'b1100000101 : 10'b0011111010;
                cur.rd   = !lastRd;
                cur.err  = 1'b0;
`else
                checkOutput("sobWithoutAccept", 1, 0);
                cur.data = 9'h0;
                cur.code = 10'h0;
                cur.rd   = 1'b0;
                cur.err  = 1'b0;
`endif
            end
`ifdef TX_IDLE_COMMA_EN
            lastRd = cur.rd;
`endif
            checkOutput("rdAtSob", rd_o, cur.rd);
            checkOutput("errAtSob", code_err_o, cur.err);
            got        = {9'b0, outputdata_o};
            bitIdx     = 1;
            collecting = 1'b1;
        end else begin
            checkOutput("errOffSob", code_err_o, 0);
            if (collecting) begin
                got = {got[8:0], outputdata_o};
                bitIdx++;
                if (bitIdx == 10) begin
                    checkOutput("codeGroup", got, cur.code);
                    collecting = 1'b0;
                end
            end
`ifndef TX_IDLE_COMMA_EN
            else begin
                checkOutput("lineIdle", outputdata_o, 0);
            end
`endif
        end
    end

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        vec_t v;
        vecs[0]  = '{9'h0B5, 10'b1010101010, 1'b0, 1'b0};
        vecs[1]  = '{9'h1BC, 10'b0011111010, 1'b1, 1'b0};
        vecs[2]  = '{9'h1BC, 10'b1100000101, 1'b0, 1'b0};
        vecs[3]  = '{9'h0F1, 10'b1000110111, 1'b1, 1'b0};
        vecs[4]  = '{9'h100, 10'b1100000101, 1'b0, 1'b1};
        vecs[5]  = '{9'h000, 10'b1001110100, 1'b0, 1'b0};
        vecs[6]  = '{9'h0EB, 10'b1101001110, 1'b1, 1'b0};
        vecs[7]  = '{9'h0EB, 10'b1101001000, 1'b0, 1'b0};
        vecs[8]  = '{9'h1FC, 10'b0011111000, 1'b0, 1'b0};
        vecs[9]  = '{9'h1F7, 10'b1110101000, 1'b0, 1'b0};
        vecs[10] = '{9'h1BC, 10'b0011111010, 1'b1, 1'b0};
        vecs[11] = '{9'h07C, 10'b0011100011, 1'b1, 1'b0};
        vecs[12] = '{9'h0B5, 10'b1010101010, 1'b1, 1'b0};
        vecs[13] = '{9'h1E1, 10'b1100000101, 1'b0, 1'b1};
        vecs[14] = '{9'h000, 10'b1001110100, 1'b0, 1'b0};

        rst_i       = 1'b0;
        valid_i     = 1'b0;
        inputdata_i = 9'h0;
        firstReady  = 1'b1;
        repeat (2) @(negedge clk_i);
        #1 checkOutput("resetState", {outputdata_o, ready_o, rd_o, sob_o, code_err_o}, 5'b01000);
        @(negedge clk_i);
        rst_i = 1'b1;

`ifdef TX_IDLE_COMMA_EN
        @(negedge clk_i);
        checkOutput("firstCommaSob", sob_o, 1);
        repeat (34) @(negedge clk_i);
        begin
            int n = 0;
            while (!(sob_o && rd_o) && n < 25) begin
                @(negedge clk_i);
                n++;
            end
            checkOutput("rdPlusCommaSeen", {sob_o, rd_o}, 2'b11);
        end
        repeat (4) @(negedge clk_i);
        checkOutput("lineBeforeReset", outputdata_o, 1);
        rst_i = 1'b0;
        #1 checkOutput("midReset", {outputdata_o, ready_o, rd_o, sob_o, code_err_o}, 5'b01000);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("commaAfterResetSob", sob_o, 1);
        repeat (15) @(negedge clk_i);
        waitDrain();
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            checkOutput("idleAfterReset", {outputdata_o, ready_o, rd_o, sob_o, code_err_o}, 5'b01000);
        end

        firstReady = 1'b1;
        for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i]);
        valid_i     = 1'b0;
        inputdata_i = 9'h1FF;
        waitDrain();
        @(negedge clk_i);
        checkOutput("idleAfterBurst", {outputdata_o, ready_o, sob_o, rd_o}, 4'b0100);

        // Reset in the middle of a K28.5 that has just moved RD to RD+
        firstReady = 1'b1;
        v = '{9'h1BC, 10'b0011111010, 1'b1, 1'b0};
        applyStimulus(v);
        valid_i = 1'b0;
        repeat (4) @(negedge clk_i);
        checkOutput("rdBeforeReset", rd_o, 1);
        checkOutput("lineBeforeReset", outputdata_o, 1);
        rst_i = 1'b0;
        #1 checkOutput("midReset", {outputdata_o, ready_o, rd_o, sob_o, code_err_o}, 5'b01000);
        sbQ.delete();
        @(negedge clk_i);
        rst_i = 1'b1;
        firstReady = 1'b1;
        applyStimulus(v);
        valid_i = 1'b0;
        waitDrain();
        @(negedge clk_i);
        checkOutput("idleAfterRecovery", {outputdata_o, ready_o, rd_o}, 3'b011);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/enc8b10b_tx.md
# enc8b10b_tx

Serial 8b/10b transmitter: accepts 9-bit symbols (8 data bits plus a K flag) over a valid/ready handshake, encodes them with running-disparity tracking and shifts the 10-bit code group out one bit per clock. It is the transmit-side counterpart of the serial 8b/10b receiver/decoder and drives that receiver's `inputdata_i` line in loopback benches and on-chip links.

## Interface
- No parameters; symbol width (9 in, 10 out) is fixed by the line code.
- `clk_i`  in  1  bit clock; one serial bit per rising edge
- `rst_i`  in  1  asynchronous, active-low reset
- `inputdata_i`  in  9  [7:0] = HGFEDCBA data, [8] = K (control) flag
- `valid_i`  in  1  `inputdata_i` holds a symbol to send
- `ready_o`  out  1  transmitter will load a symbol on this edge
- `outputdata_o`  out  1  serial line, registered
- `sob_o`  out  1  start of block: high while bit `a` of a symbol is on the line
- `code_err_o`  out  1  invalid K code was accepted; high for one cycle, aligned with `sob_o`
- `rd_o`  out  1  running disparity after the symbol on the line (0 = RD−, 1 = RD+)

## Operation
- Datapath:
  - 10-bit shift register, bit counter `cnt` 0..9, RD flag.
  - Line bit order is `a b c d e i f g h j`; `a` goes first.
  - `a`..`e` encode A..E (5b/6b); `f g h j` encode F..H (3b/4b).
- Encoding:
  - Standard 5b/6b and 3b/4b tables. The RD entering each sub-block selects its RD− or RD+ variant.
  - The RD after the 6b sub-block feeds the 4b sub-block. The RD after the 4b sub-block becomes the symbol's final RD.
  - D.x.P7/A7: use the A7 alternate (0111/1000) for x = 17, 18, 20 at RD−, and x = 11, 13, 14 at RD+.
  - Valid K codes: K28.0–K28.7, K23.7, K27.7, K29.7, K30.7.
  - Any other K=1 input is replaced by K28.5 and pulses `code_err_o`.
- FSM states:
  - IDLE: line held at 0, `ready_o` = 1, `cnt` frozen, RD held.
  - SHIFT: shifting one bit per clock; `cnt` increments each cycle.
- Load condition: `ready_o` = IDLE or (SHIFT and `cnt` = 9).
- Transitions:
  - `valid_i` & `ready_o`: encode with the current RD, load the shifter, set `cnt` = 0, go to SHIFT, update RD.
  - SHIFT, `cnt` = 9, no `valid_i`: handled per Configuration.
- `inputdata_i` is sampled only on an accepting edge; changes at any other time are ignored.

## Timing
- Reset (async assert, release synchronized by design):
  - `outputdata_o` = 0, `sob_o` = 0, `code_err_o` = 0, `rd_o` = 0 (RD−).
  - State IDLE, `ready_o` = 1.
- Latency: symbol accepted on edge N → bit `a` on `outputdata_o` after edge N, bit `j` after edge N+9.
- `sob_o` is high in the cycle after edge N.
- `rd_o` updates together with `sob_o`.
- Back-to-back: with `valid_i` held high, `ready_o` pulses for one cycle every 10 cycles and the line has no gaps between symbols.
- `ready_o` is combinational from state and `cnt` only, never from `valid_i`.
- Reset mid-symbol: the partial symbol is discarded. Line goes to 0 immediately, RD returns to RD−, IDLE on release.
- `code_err_o` and the substituted K28.5 come from the same accept; the RD update uses the K28.5 encoding.

## Configuration
- `TX_IDLE_COMMA_EN`:
  - Defined:
    - IDLE is never entered.
    - At `cnt` = 9 with no `valid_i` (including the first cycle after reset release), K28.5 is loaded with the current RD.
    - `sob_o` pulses for each comma; `ready_o` still pulses only at `cnt` = 9.
    - After reset, `ready_o` = 1 and `cnt` = 9, so the first edge loads either data or a comma.
  - Undefined:
    - At `cnt` = 9 with no `valid_i`, go to IDLE; line 0, RD held.
    - The next accept starts immediately from IDLE.

## Test plan
- Reset with `TX_IDLE_COMMA_EN` undefined, no `valid_i` for 20 cycles → `outputdata_o` = 0, `ready_o` = 1, `rd_o` = 0, `sob_o` = 0 throughout.
- From RD−, send 9'h0B5 (D21.5) → line 1,0,1,0,1,0,1,0,1,0; `sob_o` on the first bit; `rd_o` stays 0.
- From RD−, send 9'h1BC twice (K28.5) → 0,0,1,1,1,1,1,0,1,0 with `rd_o` = 1, then 1,1,0,0,0,0,0,1,0,1 with `rd_o` = 0. No gap; `ready_o` exactly every 10 cycles.
- Send 9'h100 (K0.0) → `code_err_o` = 1 for one cycle, coincident with `sob_o`; line carries K28.5 for the current RD.
- Send D17.7 (9'h0F1) at RD− → 4b sub-block is the A7 form 0111; final RD matches the encoder table.
- Assert `rst_i` = 0 at bit 4 of a symbol → line 0 and `rd_o` 0 immediately. After release, with `TX_IDLE_COMMA_EN` defined, a K28.5 (RD− form) starts on the first edge.
